bb_sram_yanitlayici: RTL

BB_SRAM_YANITLAYICI -- requirements
Module: bb_sram_yanitlayici

---
 rtl/bb_sram_yanitlayici_pkg.sv | 11 +
 rtl/bb_sram_dizi.sv | 40 ++++
 rtl/bb_sram_yanitlayici.sv | 91 +++++++++
 3 files changed

// File: rtl/bb_sram_yanitlayici_pkg.sv
// Shared constants for the SRAM responder: default address width, FSM states, counter width.
// Pure declarations; no logic, no latency, no flow control.
package bb_sram_yanitlayici_pkg;
  localparam int BB_ADRES_BIT = 8;
  localparam int BB_SAYAC_BIT = 16;

  typedef enum logic {
    TEMIZLE = 1'b0,
    HAZIR   = 1'b1
  } durum_e;
endpackage

// File: rtl/bb_sram_dizi.sv
// Storage array: 2^ADRES_BIT x 32-bit, byte-masked synchronous write, two registered read ports.
// Reads present data one cycle after the read edge; a read and write to one word return the old data.
// No backpressure: every enabled access completes at its edge; read outputs hold when not enabled.
module bb_sram_dizi #(
  parameter int ADRES_BIT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 yaz,
  input  logic [3:0]           yaz_maske,
  input  logic [ADRES_BIT-1:0] yaz_adres,
  input  logic [31:0]          yaz_veri,
  input  logic                 oku0,
  input  logic [ADRES_BIT-1:0] oku0_adres,
  input  logic                 oku1,
  input  logic [ADRES_BIT-1:0] oku1_adres,
  output logic [31:0]          dout0,
  output logic [31:0]          dout1
);
  logic [31:0] mem [2**ADRES_BIT];

  always_ff @(posedge clk_i) begin
    if (yaz) begin
      for (int i = 0; i < 4; i++) begin
        if (yaz_maske[i]) mem[yaz_adres][8*i +: 8] <= yaz_veri[8*i +: 8];
      end
    end
  end

  // Non-blocking sampling of mem gives read-before-write on a same-edge collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      if (oku0) dout0 <= mem[oku0_adres];
      if (oku1) dout1 <= mem[oku1_adres];
    end
  end
endmodule

// File: rtl/bb_sram_yanitlayici.sv
// 1RW+1R SRAM macro responder: clears the array after reset, then serves port-0/port-1 accesses.
// Reads have one-cycle latency; hazir_o rises 2^ADRES_BIT cycles after reset release.
// No backpressure: accesses during the clear are dropped. BB_SRAM_CAKISMA_SAYACI_EN builds the collision counter.
module bb_sram_yanitlayici
  import bb_sram_yanitlayici_pkg::*;
#(
  parameter int ADRES_BIT = BB_ADRES_BIT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [3:0]              wmask0,
  input  logic [ADRES_BIT-1:0]    addr0,
  input  logic [31:0]             din0,
  output logic [31:0]             dout0,
  input  logic                    csb1,
  input  logic [ADRES_BIT-1:0]    addr1,
  output logic [31:0]             dout1,
  output logic                    hazir_o,
  output logic [BB_SAYAC_BIT-1:0] cakisma_sayisi_o
);
  localparam logic [ADRES_BIT-1:0] ISARET_BIR = 1;

  durum_e               durum;
  logic [ADRES_BIT-1:0] isaret;
  logic                 acik;
  logic                 yaz;
  logic [3:0]           maske;
  logic [ADRES_BIT-1:0] yaz_adres;
  logic [31:0]          yaz_veri;
  logic                 oku0;
  logic                 oku1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum   <= TEMIZLE;
      isaret  <= '0;
      hazir_o <= 1'b0;
    end else if (durum == TEMIZLE) begin
      isaret <= isaret + ISARET_BIR;
      if (isaret == '1) begin
        durum   <= HAZIR;
        hazir_o <= 1'b1;
      end
    end
  end

  // During the clear the write port is owned by the pointer and both read ports are closed.
  assign acik      = (durum == HAZIR);
  assign yaz       = !acik || (!csb0 && !web0);
  assign maske     = acik ? wmask0 : 4'hF;
  assign yaz_adres = acik ? addr0 : isaret;
  assign yaz_veri  = acik ? din0 : 32'h0;
  assign oku0      = acik && !csb0 && web0;
  assign oku1      = acik && !csb1;

  bb_sram_dizi #(
    .ADRES_BIT (ADRES_BIT)
  ) u_dizi (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .yaz        (yaz),
    .yaz_maske  (maske),
    .yaz_adres  (yaz_adres),
    .yaz_veri   (yaz_veri),
    .oku0       (oku0),
    .oku0_adres (addr0),
    .oku1       (oku1),
    .oku1_adres (addr1),
    .dout0      (dout0),
    .dout1      (dout1)
  );

`ifdef BB_SRAM_CAKISMA_SAYACI_EN
  localparam logic [BB_SAYAC_BIT-1:0] SAYAC_BIR = 1;
  logic cakisma;

  assign cakisma = acik && !csb0 && !web0 && (wmask0 != 4'h0) && !csb1 && (addr0 == addr1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cakisma_sayisi_o <= '0;
    end else if (cakisma && (cakisma_sayisi_o != '1)) begin
      cakisma_sayisi_o <= cakisma_sayisi_o + SAYAC_BIR;
    end
  end
`else
  assign cakisma_sayisi_o = '0;
`endif
endmodule
